// File: rtl/keypad_debounce.sv
// keypad_debounce: synchronizes the keypad columns, debounces a single key
// press, freezes the row scanner while a key is down and emits a hex code
// with a one-cycle strobe per physical press.
// Build option: define KEYPAD_AUTOREPEAT_EN to repeat key_pulse while held.
//
// state        | meaning
// IDLE         | no key, scanner free-running
// DEBOUNCE     | candidate key captured, waiting for a stable level
// PRESSED      | key accepted, watching the captured column for release
// RELEASE_WAIT | captured column high, waiting for a stable release
module keypad_debounce #(
   parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
   parameter logic [23:0] REPEAT_CYCLES   = 24'd6000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] row_active,
   input  logic [3:0] cols_raw,
   output logic       hold_scan,
   output logic [3:0] key_code,
   output logic       key_pulse,
   output logic       key_held
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DEBOUNCE,
      ST_PRESSED,
      ST_RELEASE_WAIT
   } state_t;

   state_t      state, state_nx;
   logic [3:0]  sync1, cols_s;
   logic [3:0]  cap_row, cap_row_nx;
   logic [3:0]  cap_col, cap_col_nx;
   logic [15:0] cnt, cnt_nx, cnt_inc;
   logic        cnt_done, cap_released, valid_press;
   logic        hold_nx, pulse_nx, held_nx;
   logic [3:0]  code_nx;
   logic        rpt_pulse;

   function automatic logic [1:0] onehot_idx(input logic [3:0] v);
      case (v)
         4'b0010: return 2'd1;
         4'b0100: return 2'd2;
         4'b1000: return 2'd3;
         default: return 2'd0;
      endcase
   endfunction

   function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
      case ({r, c})
         4'h0: return 4'h1;
         4'h1: return 4'h2;
         4'h2: return 4'h3;
         4'h3: return 4'hA;
         4'h4: return 4'h4;
         4'h5: return 4'h5;
         4'h6: return 4'h6;
         4'h7: return 4'hB;
         4'h8: return 4'h7;
         4'h9: return 4'h8;
         4'hA: return 4'h9;
         4'hB: return 4'hC;
         4'hC: return 4'hE;
         4'hD: return 4'h0;
         4'hE: return 4'hF;
         default: return 4'hD;
      endcase
   endfunction

   // The capture cycle counts as the first stable sample, so the level is
   // accepted once the incremented count reaches DEBOUNCE_CYCLES-1.
   assign cnt_inc      = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
   assign cnt_done     = (cnt_inc == DEBOUNCE_CYCLES - 16'd1);
   assign cap_released = ((cols_s | cap_col) == 4'hF);
   assign valid_press  = $onehot(~cols_s) && $onehot(row_active);

   // Two-flop synchronizer for the asynchronous column inputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1  <= 4'hF;
         cols_s <= 4'hF;
      end else begin
         sync1  <= cols_raw;
         cols_s <= sync1;
      end
   end

`ifdef KEYPAD_AUTOREPEAT_EN
   logic [23:0] rpt_cnt, rpt_cnt_nx;
   logic        rpt_skip, rpt_skip_nx;

   // Repeat timer: the first terminal count after acceptance is skipped,
   // giving a 2x initial delay without widening the counter.
   always_comb begin
      rpt_cnt_nx  = 24'd0;
      rpt_skip_nx = 1'b1;
      rpt_pulse   = 1'b0;
      if (state == ST_PRESSED && !cap_released) begin
         if (rpt_cnt == REPEAT_CYCLES - 24'd1) begin
            rpt_skip_nx = 1'b0;
            rpt_pulse   = !rpt_skip;
         end else begin
            rpt_cnt_nx  = rpt_cnt + 24'd1;
            rpt_skip_nx = rpt_skip;
         end
      end
   end

   // Repeat timer registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rpt_cnt  <= 24'd0;
         rpt_skip <= 1'b1;
      end else begin
         rpt_cnt  <= rpt_cnt_nx;
         rpt_skip <= rpt_skip_nx;
      end
   end
`else
   logic unused_repeat;
   assign unused_repeat = ^REPEAT_CYCLES;
   assign rpt_pulse     = 1'b0;
`endif

   // Next-state and registered-output decode.
   always_comb begin
      state_nx   = state;
      cap_row_nx = cap_row;
      cap_col_nx = cap_col;
      cnt_nx     = cnt;
      hold_nx    = hold_scan;
      code_nx    = key_code;
      pulse_nx   = 1'b0;
      held_nx    = key_held;
      case (state)
         ST_IDLE: begin
            if (valid_press) begin
               cap_row_nx = row_active;
               cap_col_nx = cols_s;
               hold_nx    = 1'b1;
               cnt_nx     = 16'd0;
               state_nx   = ST_DEBOUNCE;
            end
         end
         ST_DEBOUNCE: begin
            if (cols_s == cap_col) begin
               cnt_nx = cnt_inc;
               if (cnt_done) begin
                  state_nx = ST_PRESSED;
                  code_nx  = key_map(onehot_idx(cap_row), onehot_idx(~cap_col));
                  pulse_nx = 1'b1;
                  held_nx  = 1'b1;
               end
            end else begin
               hold_nx  = 1'b0;
               state_nx = ST_IDLE;
            end
         end
         ST_PRESSED: begin
            if (cap_released) begin
               cnt_nx   = 16'd0;
               state_nx = ST_RELEASE_WAIT;
            end else begin
               pulse_nx = rpt_pulse;
            end
         end
         default: begin
            if (!cap_released) begin
               state_nx = ST_PRESSED;
            end else begin
               cnt_nx = cnt_inc;
               if (cnt_done) begin
                  held_nx  = 1'b0;
                  hold_nx  = 1'b0;
                  state_nx = ST_IDLE;
               end
            end
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         cap_row   <= 4'h0;
         cap_col   <= 4'hF;
         cnt       <= 16'd0;
         hold_scan <= 1'b0;
         key_code  <= 4'h0;
         key_pulse <= 1'b0;
         key_held  <= 1'b0;
      end else begin
         state     <= state_nx;
         cap_row   <= cap_row_nx;
         cap_col   <= cap_col_nx;
         cnt       <= cnt_nx;
         hold_scan <= hold_nx;
         key_code  <= code_nx;
         key_pulse <= pulse_nx;
         key_held  <= held_nx;
      end
   end

endmodule

// File: tb/tb_keypad_debounce.sv
// Directed bench for keypad_debounce with DEBOUNCE_CYCLES=4, REPEAT_CYCLES=10.
// Honours KEYPAD_AUTOREPEAT_EN when the design is built with it.
module tb_keypad_debounce;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] row_active;
   logic [3:0] cols_raw;
   logic       hold_scan;
   logic [3:0] key_code;
   logic       key_pulse;
   logic       key_held;

   int cyc = 0;
   int pulse_total = 0;
   int pulse_q[$];
   int n_vec = 0;
   int n_bad = 0;

   keypad_debounce #(
      .DEBOUNCE_CYCLES(16'd4),
      .REPEAT_CYCLES  (24'd10)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .row_active(row_active),
      .cols_raw  (cols_raw),
      .hold_scan (hold_scan),
      .key_code  (key_code),
      .key_pulse (key_pulse),
      .key_held  (key_held)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   // Rising-edge counter used as the time base for expected events
   always @(posedge clk) cyc <= cyc + 1;

   // Pulse log sampled mid-cycle
   always @(negedge clk) begin
      if (key_pulse) begin
         pulse_total <= pulse_total + 1;
         pulse_q.push_back(cyc);
      end
   end

   task automatic check(input string tag, input int got, input int exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance to 1 ns after the falling edge that follows rising edge k
   task automatic at(input int k);
      while (cyc < k) begin
         @(negedge clk);
         #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int p, r, base, base_q, n_got;
      logic saw_hold;
      int rpt_exp[$];

      reset      = 1'b0;
      row_active = 4'b0001;
      cols_raw   = 4'hF;
      at(3);
      check("rst_hold_scan", int'(hold_scan), 0);
      check("rst_key_code",  int'(key_code),  0);
      check("rst_key_pulse", int'(key_pulse), 0);
      check("rst_key_held",  int'(key_held),  0);
      reset = 1'b1;
      at(cyc + 3);

      // clean press: row1/col2 -> key 6
      base = pulse_total;
      p = cyc;
      row_active = 4'b0010;
      cols_raw   = 4'b1011;
      at(p + 2);  check("clean_hold_early", int'(hold_scan), 0);
      at(p + 3);  check("clean_hold",       int'(hold_scan), 1);
      at(p + 5);  check("clean_pulse_early", int'(key_pulse), 0);
      at(p + 6);
      check("clean_pulse", int'(key_pulse), 1);
      check("clean_code",  int'(key_code),  6);
      check("clean_held",  int'(key_held),  1);
      at(p + 7);
      check("clean_pulse_width", int'(key_pulse), 0);
      cols_raw = 4'hF;
      at(p + 12); check("clean_held_before_rel", int'(key_held), 1);
      at(p + 13);
      check("clean_held_after_rel", int'(key_held),  0);
      check("clean_hold_after_rel", int'(hold_scan), 0);
      check("clean_pulse_count", pulse_total - base, 1);
      at(p + 16);

      // bounce: column toggles every 2 cycles, never stable long enough
      base = pulse_total;
      saw_hold = 1'b0;
      row_active = 4'b0001;
      for (int i = 0; i < 10; i++) begin
         cols_raw = (i % 2 == 0) ? 4'b1110 : 4'b1111;
         at(cyc + 1); saw_hold |= hold_scan;
         at(cyc + 1); saw_hold |= hold_scan;
      end
      cols_raw = 4'hF;
      at(cyc + 6);
      check("bounce_saw_hold",    int'(saw_hold),  1);
      check("bounce_hold_idle",   int'(hold_scan), 0);
      check("bounce_pulse_count", pulse_total - base, 0);

      // release glitch: row3/col1 -> key 0
      base = pulse_total;
      p = cyc;
      row_active = 4'b1000;
      cols_raw   = 4'b1101;
      at(p + 6);
      check("glitch_pulse", int'(key_pulse), 1);
      check("glitch_code",  int'(key_code),  0);
      at(p + 8);  cols_raw = 4'hF;
      at(p + 10); cols_raw = 4'b1101;
      at(p + 12); cols_raw = 4'hF;
      check("glitch_held_rw", int'(key_held), 1);
      at(p + 14); check("glitch_held_repress", int'(key_held), 1);
      at(p + 17); check("glitch_held_before_rel", int'(key_held), 1);
      at(p + 18); check("glitch_held_after_rel",  int'(key_held), 0);
      at(p + 22);
      check("glitch_pulse_count", pulse_total - base, 1);
      check("glitch_code_kept",   int'(key_code), 0);

      // invalid patterns: two low columns, then a non-one-hot row
      base = pulse_total;
      saw_hold = 1'b0;
      row_active = 4'b0001;
      cols_raw   = 4'b1100;
      for (int i = 0; i < 8; i++) begin
         at(cyc + 1); saw_hold |= hold_scan;
      end
      row_active = 4'b0011;
      cols_raw   = 4'b1110;
      for (int i = 0; i < 8; i++) begin
         at(cyc + 1); saw_hold |= hold_scan;
      end
      check("invalid_hold", int'(saw_hold), 0);
      check("invalid_pulse_count", pulse_total - base, 0);
      cols_raw   = 4'hF;
      row_active = 4'b0001;
      at(cyc + 4);

      // row changes while held: captured row0/col3 -> key A
      base = pulse_total;
      p = cyc;
      row_active = 4'b0001;
      cols_raw   = 4'b0111;
      at(p + 4); row_active = 4'b1000;
      at(p + 6);
      check("rowchg_pulse", int'(key_pulse), 1);
      check("rowchg_code",  int'(key_code),  4'hA);
      at(p + 7); cols_raw = 4'hF;
      at(p + 15);
      check("rowchg_pulse_count", pulse_total - base, 1);

      // reset in the middle of a debounce: row0/col1 -> key 2
      base = pulse_total;
      p = cyc;
      row_active = 4'b0001;
      cols_raw   = 4'b1101;
      at(p + 4);
      check("rstmid_hold_before", int'(hold_scan), 1);
      reset = 1'b0;
      #1;
      check("rstmid_hold",  int'(hold_scan), 0);
      check("rstmid_code",  int'(key_code),  0);
      check("rstmid_pulse", int'(key_pulse), 0);
      check("rstmid_held",  int'(key_held),  0);
      at(cyc + 3);
      r = cyc;
      reset = 1'b1;
      at(r + 5);
      check("rstmid_no_early_pulse", pulse_total - base, 0);
      at(r + 6);
      check("rstmid_pulse_after", int'(key_pulse), 1);
      check("rstmid_code_after",  int'(key_code),  2);
      at(r + 7); cols_raw = 4'hF;
      at(r + 15);

      // long hold of key 5 (row1/col1); raw release is timed so the
      // detector sees close to 60 held cycles without a +60 repeat
`ifdef KEYPAD_AUTOREPEAT_EN
      rpt_exp = '{0, 20, 30, 40, 50};
`else
      rpt_exp = '{0};
`endif
      base_q = pulse_q.size();
      p = cyc;
      row_active = 4'b0010;
      cols_raw   = 4'b1101;
      at(p + 6);
      check("hold_code", int'(key_code), 5);
      at(p + 6 + 56); cols_raw = 4'hF;
      at(p + 6 + 70);
      n_got = pulse_q.size() - base_q;
      check("hold_pulse_count", n_got, rpt_exp.size());
      for (int i = 0; i < rpt_exp.size(); i++) begin
         if (i < n_got) check("hold_pulse_time", pulse_q[base_q + i] - (p + 6), rpt_exp[i]);
      end
      check("hold_code_final", int'(key_code), 5);
      check("hold_released",   int'(key_held), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/keypad_debounce.md
Name: keypad_debounce

Overview:
- Sits directly downstream of the keypad row scanner, between the scanner and the display/digit-shift logic.
- Consumes the one-hot active row and the raw active-low column inputs.
- Synchronizes and debounces a single key press, holds the scanner on the pressed row, and emits a 4-bit hex key code with a one-cycle press strobe.
- Each physical press yields exactly one strobe, regardless of bounce or hold time.

Parameters:
- DEBOUNCE_CYCLES, 16'd50000: clk cycles a level must be stable to accept a press or a release; legal range 2..65535.
- REPEAT_CYCLES, 24'd6000000: auto-repeat interval in clk cycles; used only with KEYPAD_AUTOREPEAT_EN.

Ports:
- clk  input  1  system clock (HSOSC-derived)
- reset  input  1  asynchronous, active-low reset
- row_active  input  4  one-hot row currently driven low by the scanner (bit0 = row0)
- cols_raw  input  4  raw keypad columns, active-low, pulled up, asynchronous to clk
- hold_scan  output  1  high = scanner must freeze on the current row
- key_code  output  4  hex code of the last accepted key
- key_pulse  output  1  one-cycle strobe when a key is accepted
- key_held  output  1  high while an accepted key remains pressed

Behaviour:
- Reset (async, reset=0):
  - state=IDLE, hold_scan=0, key_code=4'h0, key_pulse=0, key_held=0, counter=0.
  - Both synchronizer stages = 4'b1111.
- Synchronizer: 2-flop sync on cols_raw gives cols_s, with 2-cycle latency. All decisions use cols_s only.
- Valid press: cols_s has exactly one 0 bit AND row_active is one-hot. Zero or multiple low columns, or a non-one-hot row, is treated as "no key".
- Key map (row, col0..col3):
  - row0: 1 2 3 A
  - row1: 4 5 6 B
  - row2: 7 8 9 C
  - row3: E 0 F D
- State IDLE:
  - On a valid press: latch cap_row=row_active and cap_col=cols_s, set hold_scan=1, clear counter, go DEBOUNCE.
- State DEBOUNCE:
  - If cols_s == cap_col, counter++. Otherwise go IDLE, hold_scan=0, no pulse.
  - When counter == DEBOUNCE_CYCLES-1: go PRESSED. On that same edge key_code = map(cap_row, cap_col) and key_pulse=1 for exactly one cycle.
- State PRESSED:
  - key_held=1, hold_scan=1.
  - If cap_col reads high in cols_s: clear counter, go RELEASE_WAIT.
- State RELEASE_WAIT:
  - key_held stays 1.
  - If cap_col reads low again: go PRESSED, no new pulse.
  - If high for DEBOUNCE_CYCLES consecutive cycles: go IDLE, key_held=0, hold_scan=0.
- Pulse timing: latency from stable cols_raw to key_pulse = 2 (sync) + DEBOUNCE_CYCLES cycles.
- key_code holds its value between presses and never changes outside a pulse cycle.
- Second key pressed while PRESSED: ignored. Only cap_col is monitored, and no pulse is issued until full release through IDLE.
- row_active changing while hold_scan=1: ignored. The captured row is used.
- Counter: 16-bit, saturating; no wrap-around is possible within legal parameter range.
- Reset mid-operation: immediate return to reset values. An in-flight pulse is dropped.

Optional Feature:
- Macro: KEYPAD_AUTOREPEAT_EN.
- Defined:
  - In PRESSED, a 24-bit repeat counter runs.
  - The first repeat pulse comes 2*REPEAT_CYCLES after the initial pulse, then every REPEAT_CYCLES after that.
  - Each repeat pulse is a one-cycle key_pulse with unchanged key_code.
  - Repeat counter clears on entry to RELEASE_WAIT and does not advance there. A bounce back to PRESSED restarts the 2*REPEAT_CYCLES delay.
- Undefined: the repeat counter is absent and exactly one pulse is issued per press.

Test Plan:
- Reset behaviour: assert reset=0 mid-DEBOUNCE with cols_raw=4'b1101 -> all outputs 0 immediately. After release, no pulse until a full new debounce completes.
- Clean press decode (DEBOUNCE_CYCLES=4): row_active=4'b0010, cols_raw=4'b1011 held -> hold_scan=1 three cycles later, single key_pulse with key_code=4'h6 at cycle 2+4, key_held=1.
- Bounce rejection: cols_raw toggles 4'b1110/4'b1111 every 2 cycles for 20 cycles (DEBOUNCE_CYCLES=4) -> no key_pulse, hold_scan returns to 0.
- Release glitch: press row3/col1 (key 0) until accepted, release 2 cycles, press 2 cycles, release 10 cycles -> exactly one pulse with key_code=4'h0, key_held falls after the final stable release.
- Invalid input and row change during hold:
  - cols_raw=4'b1100 -> no hold_scan and no pulse.
  - Valid press row0/col3, then row_active changed to 4'b1000 during DEBOUNCE -> key_code=4'hA.
- Auto-repeat (KEYPAD_AUTOREPEAT_EN defined, REPEAT_CYCLES=10, DEBOUNCE_CYCLES=4): hold key 5 for 60 cycles after acceptance -> pulses at +0, +20, +30, +40, +50, all key_code=4'h5. Without the macro: exactly one pulse.
